// File: rtl/rf_wr_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
package wb_pkg;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned REG_W_DEF  = 3;

    localparam int unsigned REQ_WB = 0;
    localparam int unsigned REQ_MC = 1;

    typedef enum logic [0:0] {
        PRI_WB = 1'b0,
        PRI_MC = 1'b1
    } arb_state_e;
endpackage

// File: rtl/rf_wr_arbiter_if.sv
// Requester handshakes and register-file write port of the arbiter.
interface rf_wr_arbiter_if import wb_pkg::*; #(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned REG_W  = REG_W_DEF
);
    logic              wb_valid;
    logic [REG_W-1:0]  wb_reg;
    logic [DATA_W-1:0] wb_data;
    logic              wb_ready;

    logic              mc_valid;
    logic [REG_W-1:0]  mc_reg;
    logic [DATA_W-1:0] mc_data;
    logic              mc_ready;

    logic              rf_we;
    logic [REG_W-1:0]  rf_wreg;
    logic [DATA_W-1:0] rf_wdata;

    modport master (
        output wb_valid, wb_reg, wb_data,
        input  wb_ready,
        output mc_valid, mc_reg, mc_data,
        input  mc_ready,
        input  rf_we, rf_wreg, rf_wdata
    );

    modport slave (
        input  wb_valid, wb_reg, wb_data,
        output wb_ready,
        input  mc_valid, mc_reg, mc_data,
        output mc_ready,
        output rf_we, rf_wreg, rf_wdata
    );
endinterface

// File: rtl/rf_wr_arbiter_hs_checker.sv
// Per-requester valid/ready protocol monitor; pulses violation when a pending
// request is withdrawn or its payload changes before transfer.
module hs_checker import wb_pkg::*; #(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned REG_W  = REG_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic              ready,
    input  logic [REG_W-1:0]  req_reg,
    input  logic [DATA_W-1:0] data,
    output logic              violation
);
    logic              prev_valid;
    logic              prev_ready;
    logic [REG_W-1:0]  prev_reg;
    logic [DATA_W-1:0] prev_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_valid <= 1'b0;
            prev_ready <= 1'b0;
            prev_reg   <= '0;
            prev_data  <= '0;
        end else begin
            prev_valid <= valid;
            prev_ready <= ready;
            prev_reg   <= req_reg;
            prev_data  <= data;
        end
    end

    // A request left pending last cycle must still be present, unchanged.
    always_comb begin
        violation = 1'b0;
        if (prev_valid && !prev_ready)
            violation = !valid || (req_reg != prev_reg) || (data != prev_data);
    end
endmodule

// File: rtl/rf_wr_arbiter.sv
// Arbitrates the single register-file write port between the write-back path
// and a multi-cycle unit, with same-register ordering and bounded MC wait.
module rf_wr_arbiter import wb_pkg::*; #(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned REG_W    = REG_W_DEF,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    rf_wr_arbiter_if.slave bus,
    output logic           err
);
    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    arb_state_e state, state_next;
    logic [3:0] wait_cnt, cnt_next;
    logic       same_reg;
    logic       wb_grant, mc_grant;
    logic [1:0] viol;

    always_comb begin
        same_reg = bus.wb_valid && bus.mc_valid && (bus.wb_reg == bus.mc_reg);
        mc_grant = 1'b0;
        if (state == PRI_MC)
            mc_grant = bus.mc_valid;
        else
            // Same destination: the older MC write must land before WB.
            mc_grant = bus.mc_valid && (!bus.wb_valid || same_reg);
        wb_grant = bus.wb_valid && !mc_grant;
    end

    assign bus.wb_ready = wb_grant;
    assign bus.mc_ready = mc_grant;

    always_comb begin
        cnt_next = wait_cnt;
        if (!bus.mc_valid || mc_grant)
            cnt_next = '0;
        else if (wait_cnt >= MAX_CNT)
            cnt_next = MAX_CNT;
        else
            cnt_next = wait_cnt + 4'd1;

        state_next = state;
        if (state == PRI_WB) begin
            if (cnt_next == MAX_CNT)
                state_next = PRI_MC;
        end else begin
            if (mc_grant || !bus.mc_valid)
                state_next = PRI_WB;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= PRI_WB;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= cnt_next;
        end
    end

    // Registered write port; index/data hold their last value when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rf_we    <= 1'b0;
            bus.rf_wreg  <= '0;
            bus.rf_wdata <= '0;
        end else begin
            bus.rf_we <= wb_grant || mc_grant;
            if (mc_grant) begin
                bus.rf_wreg  <= bus.mc_reg;
                bus.rf_wdata <= bus.mc_data;
            end else if (wb_grant) begin
                bus.rf_wreg  <= bus.wb_reg;
                bus.rf_wdata <= bus.wb_data;
            end
        end
    end

    hs_checker #(.DATA_W(DATA_W), .REG_W(REG_W)) u_wb_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (bus.wb_valid),
        .ready     (wb_grant),
        .req_reg   (bus.wb_reg),
        .data      (bus.wb_data),
        .violation (viol[REQ_WB])
    );

    hs_checker #(.DATA_W(DATA_W), .REG_W(REG_W)) u_mc_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (bus.mc_valid),
        .ready     (mc_grant),
        .req_reg   (bus.mc_reg),
        .data      (bus.mc_data),
        .violation (viol[REQ_MC])
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err <= 1'b0;
        else
            err <= err || (|viol);
    end
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Self-checking bench for rf_wr_arbiter: directed scenarios plus randomized
// traffic checked against a request-age reference model.
module tb_rf_wr_arbiter;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned REG_W    = 3;
    localparam int unsigned MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err;
    int   errors = 0;
    int   checks = 0;
    logic [DATA_W-1:0] obs_rf [8];

    rf_wr_arbiter_if #(.DATA_W(DATA_W), .REG_W(REG_W)) bus ();

    rf_wr_arbiter #(.DATA_W(DATA_W), .REG_W(REG_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .err   (err)
    );

    always #5 clk = ~clk;

    // Register file as actually written by the DUT.
    always @(posedge clk)
        if (bus.rf_we === 1'b1) obs_rf[bus.rf_wreg] <= bus.rf_wdata;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        // Power-on reset values.
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL por_we: got %b expected 0", bus.rf_we); end
        checks++; if (bus.rf_wreg !== 3'd0) begin errors++; $display("FAIL por_wreg: got %0d expected 0", bus.rf_wreg); end
        checks++; if (bus.rf_wdata !== 16'h0) begin errors++; $display("FAIL por_wdata: got %h expected 0000", bus.rf_wdata); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL por_err: got %b expected 0", err); end
        rst_n = 1'b1;
        tick;
        bus.wb_valid = 1'b1; bus.wb_reg = 3'd4; bus.wb_data = 16'hA5A5;
        tick;
        checks++; if (bus.rf_we !== 1'b1) begin errors++; $display("FAIL pre_rst_we: got %b expected 1", bus.rf_we); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL async_rst_we: got %b expected 0", bus.rf_we); end
        checks++; if (bus.rf_wdata !== 16'h0) begin errors++; $display("FAIL async_rst_wdata: got %h expected 0000", bus.rf_wdata); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL async_rst_err: got %b expected 0", err); end
        tick;
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL in_rst_we: got %b expected 0", bus.rf_we); end
        rst_n = 1'b1;
        tick;
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_wreg !== 3'd4 || bus.rf_wdata !== 16'hA5A5) begin
            errors++; $display("FAIL post_rst_write: got we=%b reg=%0d data=%h expected we=1 reg=4 data=a5a5", bus.rf_we, bus.rf_wreg, bus.rf_wdata); end
        bus.wb_valid = 1'b0;
        tick;
    endtask

    task automatic test_wb_only;
        bus.wb_valid = 1'b1; bus.wb_reg = 3'd3; bus.wb_data = 16'hBEEF;
        #1;
        checks++; if (bus.wb_ready !== 1'b1 || bus.mc_ready !== 1'b0) begin
            errors++; $display("FAIL wb_only_ready: got wb=%b mc=%b expected wb=1 mc=0", bus.wb_ready, bus.mc_ready); end
        tick;
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_wreg !== 3'd3 || bus.rf_wdata !== 16'hBEEF) begin
            errors++; $display("FAIL wb_only_write: got we=%b reg=%0d data=%h expected we=1 reg=3 data=beef", bus.rf_we, bus.rf_wreg, bus.rf_wdata); end
        bus.wb_valid = 1'b0;
        tick;
        checks++; if (bus.rf_we !== 1'b0 || bus.rf_wreg !== 3'd3 || bus.rf_wdata !== 16'hBEEF) begin
            errors++; $display("FAIL wb_only_idle_hold: got we=%b reg=%0d data=%h expected we=0 reg=3 data=beef", bus.rf_we, bus.rf_wreg, bus.rf_wdata); end
    endtask

    task automatic test_same_reg;
        int stalls = 0;
        bus.wb_valid = 1'b1; bus.wb_reg = 3'd5; bus.wb_data = 16'h2222;
        bus.mc_valid = 1'b1; bus.mc_reg = 3'd5; bus.mc_data = 16'h1111;
        #1;
        if (!bus.wb_ready) stalls++;
        checks++; if (bus.mc_ready !== 1'b1 || bus.wb_ready !== 1'b0) begin
            errors++; $display("FAIL same_reg_first: got wb=%b mc=%b expected wb=0 mc=1", bus.wb_ready, bus.mc_ready); end
        tick;
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_wreg !== 3'd5 || bus.rf_wdata !== 16'h1111) begin
            errors++; $display("FAIL same_reg_mc_write: got we=%b reg=%0d data=%h expected we=1 reg=5 data=1111", bus.rf_we, bus.rf_wreg, bus.rf_wdata); end
        bus.mc_valid = 1'b0;
        #1;
        if (!bus.wb_ready) stalls++;
        tick;
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_wreg !== 3'd5 || bus.rf_wdata !== 16'h2222) begin
            errors++; $display("FAIL same_reg_wb_write: got we=%b reg=%0d data=%h expected we=1 reg=5 data=2222", bus.rf_we, bus.rf_wreg, bus.rf_wdata); end
        bus.wb_valid = 1'b0;
        tick;
        checks++; if (stalls != 1) begin errors++; $display("FAIL same_reg_stalls: got %0d expected 1", stalls); end
        checks++; if (obs_rf[5] !== 16'h2222) begin errors++; $display("FAIL same_reg_final: got %h expected 2222", obs_rf[5]); end
    endtask

    task automatic test_starvation;
        bit wb_stalled = 1'b0;
        bit exp_mc;
        logic [REG_W-1:0]  exp_reg;
        logic [DATA_W-1:0] exp_dat;
        bus.mc_valid = 1'b1; bus.mc_reg = 3'd2; bus.mc_data = 16'h2000;
        for (int unsigned c = 1; c <= 10; c++) begin
            bus.wb_valid = 1'b1; bus.wb_reg = 3'd1;
            if (!wb_stalled) bus.wb_data = 16'(16'h1000 + c);
            #1;
            exp_mc = (c == 5 || c == 10);
            checks++; if (bus.mc_ready !== exp_mc || bus.wb_ready !== !exp_mc) begin
                errors++; $display("FAIL starve_c%0d_ready: got wb=%b mc=%b expected wb=%b mc=%b", c, bus.wb_ready, bus.mc_ready, !exp_mc, exp_mc); end
            exp_reg = exp_mc ? bus.mc_reg : bus.wb_reg;
            exp_dat = exp_mc ? bus.mc_data : bus.wb_data;
            wb_stalled = exp_mc;
            tick;
            checks++; if (bus.rf_we !== 1'b1 || bus.rf_wreg !== exp_reg || bus.rf_wdata !== exp_dat) begin
                errors++; $display("FAIL starve_c%0d_write: got we=%b reg=%0d data=%h expected we=1 reg=%0d data=%h", c, bus.rf_we, bus.rf_wreg, bus.rf_wdata, exp_reg, exp_dat); end
            if (exp_mc) bus.mc_data = 16'h2001;
        end
        bus.mc_valid = 1'b0;
        #1;
        checks++; if (bus.wb_ready !== 1'b1) begin errors++; $display("FAIL starve_wb_resume: got %b expected 1", bus.wb_ready); end
        tick;
        bus.wb_valid = 1'b0;
        tick;
    endtask

    task automatic test_simultaneous;
        bus.wb_valid = 1'b1; bus.wb_reg = 3'd1; bus.wb_data = 16'h0101;
        bus.mc_valid = 1'b1; bus.mc_reg = 3'd6; bus.mc_data = 16'h0606;
        #1;
        checks++; if (bus.wb_ready !== 1'b1 || bus.mc_ready !== 1'b0) begin
            errors++; $display("FAIL simul_first: got wb=%b mc=%b expected wb=1 mc=0", bus.wb_ready, bus.mc_ready); end
        tick;
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_wreg !== 3'd1 || bus.rf_wdata !== 16'h0101) begin
            errors++; $display("FAIL simul_r1: got we=%b reg=%0d data=%h expected we=1 reg=1 data=0101", bus.rf_we, bus.rf_wreg, bus.rf_wdata); end
        bus.wb_valid = 1'b0;
        #1;
        checks++; if (bus.mc_ready !== 1'b1) begin errors++; $display("FAIL simul_mc_ready: got %b expected 1", bus.mc_ready); end
        tick;
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_wreg !== 3'd6 || bus.rf_wdata !== 16'h0606) begin
            errors++; $display("FAIL simul_r6: got we=%b reg=%0d data=%h expected we=1 reg=6 data=0606", bus.rf_we, bus.rf_wreg, bus.rf_wdata); end
        bus.mc_valid = 1'b0;
        tick;
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL simul_idle: got %b expected 0", bus.rf_we); end
    endtask

    // Reference: MC wins when WB is absent, targets the same register, or MC
    // has already gone unserved for MAX_WAIT consecutive cycles.
    task automatic test_random(input int unsigned n);
        int unsigned age = 0;
        bit wg, mg, have_last = 1'b0;
        logic [REG_W-1:0]  exp_reg = '0;
        logic [DATA_W-1:0] exp_dat = '0;
        for (int unsigned c = 0; c < n + 40; c++) begin
            if (c >= n && !bus.wb_valid && !bus.mc_valid) break;
            if (c < n && !bus.wb_valid && $urandom_range(0, 2) != 0) begin
                bus.wb_valid = 1'b1; bus.wb_reg = 3'($urandom); bus.wb_data = 16'($urandom);
            end
            if (c < n && !bus.mc_valid && $urandom_range(0, 2) == 0) begin
                bus.mc_valid = 1'b1; bus.mc_data = 16'($urandom);
                bus.mc_reg = ($urandom_range(0, 3) == 0) ? bus.wb_reg : 3'($urandom);
            end
            #1;
            mg = bus.mc_valid && (!bus.wb_valid || bus.mc_reg == bus.wb_reg || age >= MAX_WAIT);
            wg = bus.wb_valid && !mg;
            checks++; if (bus.wb_ready !== wg || bus.mc_ready !== mg) begin
                errors++; $display("FAIL rand_c%0d_ready: got wb=%b mc=%b expected wb=%b mc=%b", c, bus.wb_ready, bus.mc_ready, wg, mg); end
            if (mg) begin exp_reg = bus.mc_reg; exp_dat = bus.mc_data; have_last = 1'b1; end
            else if (wg) begin exp_reg = bus.wb_reg; exp_dat = bus.wb_data; have_last = 1'b1; end
            tick;
            checks++; if (bus.rf_we !== (wg | mg)) begin
                errors++; $display("FAIL rand_c%0d_we: got %b expected %b", c, bus.rf_we, wg | mg); end
            if (have_last) begin
                checks++; if (bus.rf_wreg !== exp_reg || bus.rf_wdata !== exp_dat) begin
                    errors++; $display("FAIL rand_c%0d_payload: got reg=%0d data=%h expected reg=%0d data=%h", c, bus.rf_wreg, bus.rf_wdata, exp_reg, exp_dat); end
            end
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL rand_c%0d_err: got %b expected 0", c, err); end
            age = (bus.mc_valid && !mg) ? age + 1 : 0;
            if (wg) bus.wb_valid = 1'b0;
            if (mg) bus.mc_valid = 1'b0;
        end
        checks++; if (bus.wb_valid !== 1'b0 || bus.mc_valid !== 1'b0) begin
            errors++; $display("FAIL rand_drain: got wb=%b mc=%b pending expected both served", bus.wb_valid, bus.mc_valid); end
        bus.wb_valid = 1'b0; bus.mc_valid = 1'b0;
        tick;
    endtask

    task automatic test_protocol_err;
        bus.wb_valid = 1'b1; bus.wb_reg = 3'd0; bus.wb_data = 16'h0100;
        bus.mc_valid = 1'b1; bus.mc_reg = 3'd7; bus.mc_data = 16'h0001;
        tick;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL perr_before: got %b expected 0", err); end
        bus.wb_data = 16'h0101; bus.mc_data = 16'h0002;
        tick;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL perr_data_change: got %b expected 1", err); end
        bus.wb_valid = 1'b0;
        #1;
        checks++; if (bus.mc_ready !== 1'b1) begin errors++; $display("FAIL perr_arb_continues: got %b expected 1", bus.mc_ready); end
        tick;
        bus.mc_valid = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            bus.wb_valid = 1'b1; bus.wb_reg = 3'($urandom); bus.wb_data = 16'($urandom);
            tick;
            checks++; if (err !== 1'b1) begin errors++; $display("FAIL perr_sticky_%0d: got %b expected 1", i, err); end
            bus.wb_valid = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL perr_reset: got %b expected 0", err); end
        tick;
        rst_n = 1'b1;
        tick;
        bus.wb_valid = 1'b1; bus.wb_reg = 3'd1; bus.wb_data = 16'h00AA;
        bus.mc_valid = 1'b1; bus.mc_reg = 3'd2; bus.mc_data = 16'h00BB;
        tick;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL pdrop_before: got %b expected 0", err); end
        bus.wb_valid = 1'b0; bus.mc_valid = 1'b0;
        tick;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL pdrop_valid_fall: got %b expected 1", err); end
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    initial begin
        bus.wb_valid = 1'b0; bus.wb_reg = '0; bus.wb_data = '0;
        bus.mc_valid = 1'b0; bus.mc_reg = '0; bus.mc_data = '0;
        for (int i = 0; i < 8; i++) obs_rf[i] = '0;
        tick;
        tick;
        test_reset;
        test_wb_only;
        test_same_reg;
        test_starvation;
        test_simultaneous;
        test_random(400);
        test_protocol_err;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rf_wr_arbiter.md
Name: rf_wr_arbiter

Overview:
- Shares the single register-file write port between two requesters.
  - The in-order pipeline write-back path: write_data plus destination register.
  - A multi-cycle unit (multi-cycle data-memory load return / long-latency ALU op).
- Sits between the write-back stage and the register file.
- Drives stall back to the pipeline when the write-back path loses arbitration.
- Enforces write ordering and starvation freedom; flags handshake protocol violations.

Parameters:
- DATA_W, 16, write data width.
- REG_W, 3, register index width (8 GPRs; R0 is an ordinary register).
- MAX_WAIT, 4, cycles the multi-cycle requester may wait before it gains priority (range 1..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wb_valid  in  1  write-back stage has a register write.
- wb_reg  in  REG_W  write-back destination register.
- wb_data  in  DATA_W  write-back data.
- wb_ready  out  1  write-back request granted this cycle (pipeline stalls while wb_valid && !wb_ready).
- mc_valid  in  1  multi-cycle unit has a register write.
- mc_reg  in  REG_W  multi-cycle destination register.
- mc_data  in  DATA_W  multi-cycle data.
- mc_ready  out  1  multi-cycle request granted this cycle.
- rf_we  out  1  register-file write enable.
- rf_wreg  out  REG_W  register-file write index.
- rf_wdata  out  DATA_W  register-file write data.
- err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (async, rst_n=0): rf_we=0, rf_wreg=0, rf_wdata=0, err=0, wait counter=0, FSM=PRI_WB.
  - Reset mid-request drops any in-flight grant; requesters re-present after release.
- Handshake:
  - valid/ready; a transfer occurs in a cycle where valid && ready.
  - Once raised, valid and payload (reg, data) stay stable until transfer.
  - wb_ready and mc_ready are combinational from FSM state and both valids.
  - At most one ready is high per cycle; ready is never high without its valid.
- Latency: a granted request appears on rf_we/rf_wreg/rf_wdata exactly one cycle after the handshake (registered output). rf_we is high for exactly one cycle per transfer.
- FSM states:
  - PRI_WB: grant WB if wb_valid, else MC if mc_valid. Exception: if both valid and mc_reg == wb_reg, grant MC (the older write lands first; the WB write follows next cycle, so the final value is the WB data).
  - PRI_MC: grant MC if mc_valid, else WB if wb_valid.
- Wait counter (4 bits, saturating at MAX_WAIT):
  - Increments each cycle with mc_valid && !mc_ready.
  - Clears on MC transfer, or when mc_valid is low.
- Transitions:
  - PRI_WB -> PRI_MC on the edge where the counter's next value equals MAX_WAIT.
  - PRI_MC -> PRI_WB on the edge of any MC transfer, or when mc_valid is low.
- Guarantees:
  - MC is granted within MAX_WAIT+1 cycles of raising valid.
  - WB is stalled at most 1 cycle per MC grant when not same-register.
- Idle (neither valid): rf_we=0 next cycle; rf_wreg/rf_wdata hold their last values.
- err is set (held until reset) when either:
  - a valid falls without a transfer, or
  - reg/data change while valid && !ready.
  - Arbitration continues normally after err.

Decomposition:
- Shared package `wb_pkg`:
  - FSM state enum {PRI_WB, PRI_MC}.
  - DATA_W / REG_W defaults.
  - Requester index constants (REQ_WB=0, REQ_MC=1).
- One sub-module: `hs_checker`, instantiated once per requester. It registers the previous valid/ready/payload and outputs a violation pulse; the two pulses are OR'd into sticky err.

Test Plan:
- Reset: hold rst_n=0 mid-cycle with wb_valid=1 -> rf_we=0, err=0 immediately (async); after release, WB grant appears 1 cycle later.
- WB only: wb_valid=1, wb_reg=3, wb_data=16'hBEEF -> wb_ready=1 same cycle; next cycle rf_we=1, rf_wreg=3, rf_wdata=16'hBEEF; then rf_we=0.
- Same-register conflict: both valid, mc_reg=wb_reg=5, mc_data=16'h1111, wb_data=16'h2222 -> MC granted first, WB next cycle; R5 ends as 16'h2222; WB stalled exactly 1 cycle.
- Starvation (MAX_WAIT=4): wb_valid=1 every cycle with new data, mc_valid=1 with mc_reg=2 -> mc_ready=1 on the 5th cycle of mc_valid; WB stalled that cycle; FSM back to PRI_WB after.
- Simultaneous, different regs, PRI_WB: wb_reg=1, mc_reg=6 -> WB granted, MC waits; with wb_valid then low, MC granted the following cycle; rf writes R1 then R6 on consecutive cycles.
- Protocol violation: mc_valid=1 not granted, change mc_data 16'h0001->16'h0002 -> err=1 next edge, stays 1 through later traffic until rst_n=0.
